// File: rtl/vector_sequencer_if.sv
// Stimulus/response handshake bundle between the vector sequencer (master)
// and the unit under test (slave).
interface vector_sequencer_if #(
   parameter int DW = 8
);
   logic          stim_valid;
   logic [DW-1:0] stim_data;
   logic          stim_ready;
   logic          resp_valid;
   logic [DW-1:0] resp_data;

   modport master (
      output stim_valid,
      output stim_data,
      input  stim_ready,
      input  resp_valid,
      input  resp_data
   );

   modport slave (
      input  stim_valid,
      input  stim_data,
      output stim_ready,
      output resp_valid,
      output resp_data
   );
endinterface

// File: rtl/vector_sequencer.sv
// Vector sequencer: issues (stimulus, expected) pairs from a loadable table
// to the UUT over valid/ready, checks each response and keeps pass/fail/
// timeout tallies plus the index of the first failing vector.
module vector_sequencer #(
   parameter int DW  = 8,
   parameter int AW  = 4,
   parameter int TMO = 15
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [AW:0]         num_vec,
   input  logic                vec_we,
   input  logic [AW-1:0]       vec_addr,
   input  logic [DW-1:0]       vec_stim,
   input  logic [DW-1:0]       vec_exp,
   vector_sequencer_if.master  bus,
   output logic                busy,
   output logic                done,
   output logic [AW:0]         pass_cnt,
   output logic [AW:0]         fail_cnt,
   output logic [AW:0]         tmo_cnt,
   output logic [AW-1:0]       first_fail_idx,
   output logic                first_fail_vld
);

   localparam int          DEPTH    = 2**AW;
   localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
   localparam logic [7:0]  TMO_LAST = 8'(TMO - 1);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_DONE} state_t;

   state_t        state_q, state_n;
   logic [DW-1:0] stim_mem [DEPTH];
   logic [DW-1:0] exp_mem  [DEPTH];
   logic [AW-1:0] idx_q;
   logic [AW-1:0] idx_nxt;
   logic [AW:0]   num_q;
   logic [7:0]    tmo_q;
   logic [DW-1:0] resp_q;
   logic          stim_valid_q;
   logic [DW-1:0] stim_data_q;
   logic          start_ok;
   logic          last;
   logic          advance;
   logic          chk_fail;
   logic          tmo_hit;

   assign start_ok = start && (state_q == S_IDLE || state_q == S_DONE);
   assign idx_nxt  = idx_q + AW'(1);
   assign last     = ({1'b0, idx_q} + (AW+1)'(1)) == num_q;

   assign bus.stim_valid = stim_valid_q;
   assign bus.stim_data  = stim_data_q;
   assign busy = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_CHECK);
   assign done = (state_q == S_DONE);

   // Vector table write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (vec_we) begin
         stim_mem[vec_addr] <= vec_stim;
         exp_mem[vec_addr]  <= vec_exp;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_n;
   end

   // Next state plus the per-vector advance/verdict strobes.
   always_comb begin
      state_n  = state_q;
      advance  = 1'b0;
      chk_fail = 1'b0;
      tmo_hit  = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) state_n = (num_vec == '0) ? S_DONE : S_ISSUE;
         end
         S_ISSUE: begin
            if (bus.stim_ready) state_n = S_WAIT;
         end
         S_WAIT: begin
            if (bus.resp_valid) begin
               state_n = S_CHECK;
            end else if (tmo_q == TMO_LAST) begin
               tmo_hit = 1'b1;
               advance = 1'b1;
            end
         end
         S_CHECK: begin
            advance  = 1'b1;
            chk_fail = (resp_q != exp_mem[idx_q]);
         end
         default: state_n = S_IDLE;
      endcase
      if (advance) state_n = last ? S_DONE : S_ISSUE;
   end

   // Datapath: stimulus register, timeout counter, response capture, tallies.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stim_valid_q   <= 1'b0;
         stim_data_q    <= '0;
         idx_q          <= '0;
         num_q          <= '0;
         tmo_q          <= '0;
         resp_q         <= '0;
         pass_cnt       <= '0;
         fail_cnt       <= '0;
         tmo_cnt        <= '0;
         first_fail_idx <= '0;
         first_fail_vld <= 1'b0;
      end else begin
         if (start_ok) begin
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            tmo_cnt        <= '0;
            first_fail_idx <= '0;
            first_fail_vld <= 1'b0;
            idx_q          <= '0;
            num_q          <= (num_vec > DEPTH_C) ? DEPTH_C : num_vec;
            if (num_vec != '0) begin
               stim_valid_q <= 1'b1;
               stim_data_q  <= stim_mem[AW'(0)];
            end
         end
         if (state_q == S_ISSUE && bus.stim_ready) begin
            stim_valid_q <= 1'b0;
            tmo_q        <= '0;
         end
         if (state_q == S_WAIT) begin
            if (bus.resp_valid) resp_q <= bus.resp_data;
            else if (!tmo_hit)  tmo_q  <= tmo_q + 8'd1;
         end
         if (advance) begin
            if (chk_fail || tmo_hit) begin
               fail_cnt <= fail_cnt + (AW+1)'(1);
               if (tmo_hit) tmo_cnt <= tmo_cnt + (AW+1)'(1);
               if (!first_fail_vld) begin
                  first_fail_idx <= idx_q;
                  first_fail_vld <= 1'b1;
               end
            end else begin
               pass_cnt <= pass_cnt + (AW+1)'(1);
            end
            // Next stimulus is registered on the advance edge so it is valid
            // on the very first ISSUE cycle.
            if (!last) begin
               idx_q        <= idx_nxt;
               stim_valid_q <= 1'b1;
               stim_data_q  <= stim_mem[idx_nxt];
            end
         end
      end
   end

endmodule

// File: tb/tb_vector_sequencer.sv
// Directed bench for vector_sequencer: a behavioural UUT answers each
// accepted stimulus two clock edges after acceptance, with optional
// stalling, dropping and corruption controlled by the stimulus thread.
module tb_vector_sequencer;

   localparam int DW = 8;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW:0]   num_vec;
   logic          vec_we;
   logic [AW-1:0] vec_addr;
   logic [DW-1:0] vec_stim;
   logic [DW-1:0] vec_exp;
   logic          busy;
   logic          done;
   logic [AW:0]   pass_cnt;
   logic [AW:0]   fail_cnt;
   logic [AW:0]   tmo_cnt;
   logic [AW-1:0] first_fail_idx;
   logic          first_fail_vld;

   int checks = 0;
   int errors = 0;

   // UUT model controls/observations
   int issue_num  = 0;
   int stall_idx  = -1;
   int stall_left = 0;
   int stall_seen = 0;
   int stall_bad  = 0;
   int drop_idx   = -1;
   int busy_cycles;
   int guard;

   vector_sequencer_if #(.DW(DW)) bus ();

   vector_sequencer #(.DW(DW), .AW(AW), .TMO(15)) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .num_vec        (num_vec),
      .vec_we         (vec_we),
      .vec_addr       (vec_addr),
      .vec_stim       (vec_stim),
      .vec_exp        (vec_exp),
      .bus            (bus.master),
      .busy           (busy),
      .done           (done),
      .pass_cnt       (pass_cnt),
      .fail_cnt       (fail_cnt),
      .tmo_cnt        (tmo_cnt),
      .first_fail_idx (first_fail_idx),
      .first_fail_vld (first_fail_vld)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic load(input int a, input logic [DW-1:0] s, input logic [DW-1:0] e);
      @(negedge clk);
      vec_we = 1'b1; vec_addr = AW'(a); vec_stim = s; vec_exp = e;
      @(negedge clk);
      vec_we = 1'b0;
   endtask

   // Pulse start, optionally re-pulse start (num_vec = 0) at cycle 'poke',
   // then wait for done with a bounded cycle budget.
   task automatic run(input logic [AW:0] n, input int poke);
      @(negedge clk);
      issue_num = 0;
      num_vec = n;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      guard = 0;
      busy_cycles = 0;
      while (!done && guard < 3000) begin
         if (busy) busy_cycles++;
         if (guard == poke) begin start = 1'b1; num_vec = '0; end
         else start = 1'b0;
         @(negedge clk);
         guard++;
      end
      start = 1'b0;
      chk("run_done", done, 1);
   endtask

   // Behavioural UUT: ready at negedge, response two edges after acceptance.
   initial begin
      int n;
      logic [DW-1:0] d;
      bus.stim_ready = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_data  = '0;
      forever begin
         @(negedge clk);
         if (bus.stim_valid && issue_num == stall_idx && stall_left > 0) begin
            bus.stim_ready = 1'b0;
            stall_left--;
            stall_seen++;
            if (bus.stim_data !== 8'h22) stall_bad++;
         end else begin
            bus.stim_ready = 1'b1;
         end
         if (bus.stim_valid && bus.stim_ready) begin
            d = bus.stim_data;
            n = issue_num;
            issue_num++;
            @(posedge clk);
            @(posedge clk);
            #1;
            if (n != drop_idx) begin
               bus.resp_valid = 1'b1;
               bus.resp_data  = d;
               @(posedge clk);
               #1;
               bus.resp_valid = 1'b0;
            end
         end
      end
   end

   initial begin
      reset = 1'b1; start = 1'b0; num_vec = '0;
      vec_we = 1'b0; vec_addr = '0; vec_stim = '0; vec_exp = '0;
      repeat (3) @(negedge clk);
      chk("rst_stim_valid", bus.stim_valid, 0);
      chk("rst_stim_data", bus.stim_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass_cnt, 0);
      chk("rst_ffvld", first_fail_vld, 0);
      reset = 1'b0;

      // Loopback pass
      load(0, 8'h11, 8'h11);
      load(1, 8'h22, 8'h22);
      load(2, 8'h33, 8'h33);
      load(3, 8'h44, 8'h44);
      run(5'd4, -1);
      chk("lb_pass", pass_cnt, 4);
      chk("lb_fail", fail_cnt, 0);
      chk("lb_tmo", tmo_cnt, 0);
      chk("lb_ffvld", first_fail_vld, 0);
      chk("lb_busy_cycles", busy_cycles, 16);
      chk("lb_issues", issue_num, 4);
      @(negedge clk);
      chk("lb_done_held", done, 1);

      // Mismatch on vector 2
      load(2, 8'h33, 8'h35);
      run(5'd4, -1);
      chk("mm_pass", pass_cnt, 3);
      chk("mm_fail", fail_cnt, 1);
      chk("mm_tmo", tmo_cnt, 0);
      chk("mm_ffidx", first_fail_idx, 2);
      chk("mm_ffvld", first_fail_vld, 1);
      load(2, 8'h33, 8'h33);

      // Backpressure: 5 stalled cycles on vector 1
      stall_idx = 1; stall_left = 5; stall_seen = 0; stall_bad = 0;
      run(5'd4, -1);
      stall_idx = -1;
      chk("bp_pass", pass_cnt, 4);
      chk("bp_stall_cycles", stall_seen, 5);
      chk("bp_stall_data", stall_bad, 0);
      chk("bp_issues", issue_num, 4);
      chk("bp_busy_cycles", busy_cycles, 21);

      // Timeout: vector 0 never answered
      drop_idx = 0;
      run(5'd4, -1);
      drop_idx = -1;
      chk("to_tmo", tmo_cnt, 1);
      chk("to_fail", fail_cnt, 1);
      chk("to_pass", pass_cnt, 3);
      chk("to_ffidx", first_fail_idx, 0);
      chk("to_ffvld", first_fail_vld, 1);
      chk("to_busy_cycles", busy_cycles, 28);

      // Reset during WAIT of vector 2
      @(negedge clk);
      issue_num = 0; num_vec = 5'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      guard = 0;
      while (issue_num != 3 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      chk("rm_reached_v2", issue_num, 3);
      @(posedge clk);
      #1;
      chk("rm_pass_before", pass_cnt, 2);
      reset = 1'b1;
      #1;
      chk("rm_stim_valid", bus.stim_valid, 0);
      chk("rm_stim_data", bus.stim_data, 0);
      chk("rm_busy", busy, 0);
      chk("rm_done", done, 0);
      chk("rm_pass", pass_cnt, 0);
      chk("rm_ffvld", first_fail_vld, 0);
      repeat (4) @(negedge clk);
      reset = 1'b0;
      run(5'd4, -1);
      chk("rm_rerun_pass", pass_cnt, 4);
      chk("rm_rerun_fail", fail_cnt, 0);

      // num_vec = 0
      run(5'd0, -1);
      chk("z_latency", (guard <= 2) ? 1 : 0, 1);
      chk("z_busy_cycles", busy_cycles, 0);
      chk("z_pass", pass_cnt, 0);
      chk("z_fail", fail_cnt, 0);

      // Full table, then clamped over-length run
      for (int i = 0; i < 16; i++) load(i, 8'(i * 7 + 3), 8'(i * 7 + 3));
      run(5'd16, -1);
      chk("full_pass", pass_cnt, 16);
      chk("full_fail", fail_cnt, 0);
      chk("full_busy_cycles", busy_cycles, 64);
      run(5'd31, -1);
      chk("clamp_pass", pass_cnt, 16);
      chk("clamp_busy_cycles", busy_cycles, 64);

      // start while busy is ignored
      run(5'd4, 5);
      chk("sb_pass", pass_cnt, 4);
      chk("sb_busy_cycles", busy_cycles, 16);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
